// File: rtl/bcd2gray_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2gray_arbiter
//  Description : Round-robin arbiter sharing one registered BCD-to-Gray
//                converter among NREQ requesters. The result is held on a
//                valid/ack handshake, non-BCD codes are flagged, and an
//                8-bit saturating error count is kept.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2gray_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] bcd_in,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  output logic [IDW-1:0]    out_id,
  output logic [3:0]        gray_out,
  output logic              bcd_err,
  input  logic              out_ack,
  output logic [7:0]        err_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      gray_q, gray_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [3:0]      win_digit;

  // Round-robin search: first set request starting one past the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == ((int'(last_q) + k) % NREQ))) begin
          found = 1'b1;
          win   = IDW'(i);
        end
      end
    end
  end

  // Select only the winning requester's digit; other lanes are never used
  always_comb begin
    win_digit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        win_digit = bcd_in[4*i +: 4];
      end
    end
  end

  // Next-state logic: grant and capture in IDLE, hold result until ack
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    gnt_d   = '0;
    gray_d  = gray_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << win;
          id_d    = win;
          last_d  = win;
          gray_d  = {win_digit[3],
                     win_digit[3] ^ win_digit[2],
                     win_digit[2] ^ win_digit[1],
                     win_digit[1] ^ win_digit[0]};
          err_d   = (win_digit > 4'd9);
          if ((win_digit > 4'd9) && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
          end
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      gnt_q   <= '0;
      gray_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      gray_q  <= gray_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = (state_q == ST_HOLD);
  assign out_id    = id_q;
  assign gray_out  = gray_q;
  assign bcd_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: doc/bcd2gray_arbiter.md
Name: bcd2gray_arbiter

Overview:
- Shares one registered BCD-to-Gray conversion unit among NREQ requesters.
- Round-robin arbitration; grant is a one-cycle pulse.
- The winner's 4-bit BCD digit is captured, converted and held on a valid/ack output handshake until the consumer accepts it.
- Also flags non-BCD codes (>9) and keeps a saturating error count, for display/encoder front-ends that share a single converter.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of out_id; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester request level.
- bcd_in  input  4*NREQ  packed digits; requester i on bits [4i+3:4i].
- gnt  output  NREQ  one-hot grant pulse, registered.
- out_valid  output  1  converted result valid.
- out_id  output  IDW  index of the requester owning the current result.
- gray_out  output  4  Gray code of the captured digit.
- bcd_err  output  1  captured digit > 9.
- out_ack  input  1  consumer accepts the result; sampled only while out_valid=1.
- err_cnt  output  8  saturating count of captured invalid digits.

Behaviour:
- Reset (rst_n=0 at a rising edge) clears everything regardless of state:
  - gnt=0, out_valid=0, out_id=0, gray_out=0, bcd_err=0, err_cnt=0.
  - State=IDLE, last-grant pointer=NREQ-1, so requester 0 has top priority after reset.
  - An in-flight result is discarded; no ack is required.
- States:
  - IDLE: out_valid=0. If any req bit is 1, a combinational round-robin search starts at (last+1) mod NREQ and picks the first set bit, winner w. At the edge:
    - gnt[w]=1 for exactly one cycle.
    - Capture bcd_in[w].
    - out_id=w, last=w.
    - gray_out = {b3, b3^b2, b2^b1, b1^b0}.
    - bcd_err = (captured > 9); err_cnt increments if bcd_err and err_cnt < 255.
    - State goes to HOLD.
    - If no req bit is set, stay in IDLE with gnt=0.
  - HOLD: out_valid=1; gnt=0; out_id, gray_out and bcd_err remain stable.
    - out_ack=1 -> IDLE at the edge; out_valid=0 the following cycle.
    - out_ack=0 -> stay in HOLD.
- Latency:
  - req sampled in IDLE at cycle t -> gnt pulse and out_valid=1 at t+1.
  - Minimum 2 cycles per conversion: a HOLD with immediate ack is followed by a mandatory IDLE cycle before the next grant.
- Requester rules:
  - Hold req and bcd_in stable until gnt is seen.
  - Deassert req in the cycle after the gnt pulse; a req still high in a later IDLE cycle counts as a new request.
  - req changes during HOLD are ignored until IDLE.
- out_ack while out_valid=0 has no effect.
- Out-of-range inputs are not rejected: gray_out is defined for all 16 codes, and bcd_err only reports the condition.
- err_cnt saturates at 255 and is cleared only by reset.
- bcd_in of non-winning requesters is never sampled.
- Simultaneous requests resolve purely by the round-robin pointer; there is no fixed priority except immediately after reset.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req=4'b1111, out_ack=1 -> gnt=0000, out_valid=0, gray_out=0000, err_cnt=0.
2. Single request: req=4'b0100, bcd_in digit2=4'd7 -> next cycle gnt=0100, out_valid=1, out_id=2, gray_out=0100, bcd_err=0. Hold 3 cycles without ack -> outputs stable. Ack -> out_valid=0 next cycle.
3. Fairness: req=4'b1111 re-asserted every IDLE cycle, ack on the first HOLD cycle -> grant order 0,1,2,3,0,1; gnt pulses 2 cycles apart.
4. Invalid digit: digit0=4'hC -> gray_out=1010, bcd_err=1, err_cnt=1. 260 consecutive invalid captures -> err_cnt=255 and holds there.
5. Reset mid-HOLD with digit 9 pending:
   - rst_n=0 for one cycle -> out_valid=0.
   - Then req=4'b1001 -> gnt=0001 first, then 1000 on the next arbitration.
6. Exhaustive conversion: digits 0..15 via requester 1 -> gray_out matches the formula for every code; bcd_err=1 exactly for 10..15.
